// File: rtl/cc_arb_pkg.sv
// Shared definitions for the two-port cache arbiter.
// Holds the FSM state encoding, requester count and the default WAIT timeout.
package cc_arb_pkg;

    // Number of requesters sharing the cache controller
    localparam int NUM_REQ = 2;

    // Default WAIT-state cycle limit when the timeout feature is built in
    localparam int DEF_TIMEOUT_CYCLES = 16;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/arb_rr_pick.sv
// Round-robin winner selection for the cache arbiter.
// Ports: req  - request vector (bit N = requester N)
//        ptr  - preferred requester when both request (0 = req0)
//        grant - one-hot grant, all zero when nothing requests
module arb_rr_pick
    import cc_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               ptr,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        if (req[0] && req[1]) begin
            // contention: the pointer names the requester not served last
            grant[ptr] = 1'b1;
        end else begin
            // zero or one request: pass it straight through
            grant = req;
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Arbitrates two requesters onto one cache_controller port (IDLE/ISSUE/WAIT/DONE).
// Ports: CC_clk, rst (sync, active-high); per requester N: reqN, opN, addrN,
//        wdataN in, ackN, rdataN, hitN, errN out; cache side: start,
//        read_operation, address, write_data out, read_data, hit, miss in;
//        busy out. Optional WAIT timeout built in when ARB_TIMEOUT_EN is defined.
module cache_port_arbiter
    import cc_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int AW             = 8
) (
    input  logic          CC_clk,
    input  logic          rst,

    input  logic          req0,
    input  logic          op0,
    input  logic [AW-1:0] addr0,
    input  logic [7:0]    wdata0,
    output logic          ack0,
    output logic [7:0]    rdata0,
    output logic          hit0,
    output logic          err0,

    input  logic          req1,
    input  logic          op1,
    input  logic [AW-1:0] addr1,
    input  logic [7:0]    wdata1,
    output logic          ack1,
    output logic [7:0]    rdata1,
    output logic          hit1,
    output logic          err1,

    output logic          start,
    output logic          read_operation,
    output logic [AW-1:0] address,
    output logic [7:0]    write_data,
    input  logic [7:0]    read_data,
    input  logic          hit,
    input  logic          miss,

    output logic          busy
);

    arb_state_e         state;
    logic               ptr;
    logic               sel;
    logic [7:0]         cap_data;
    logic               cap_hit;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;

    assign req = {req1, req0};

    arb_rr_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (grant)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          cap_err;

    always_ff @(posedge CC_clk) begin
        if (rst) begin
            state          <= S_IDLE;
            ptr            <= 1'b0;
            sel            <= 1'b0;
            cap_data       <= '0;
            cap_hit        <= 1'b0;
            cap_err        <= 1'b0;
            cnt            <= '0;
            start          <= 1'b0;
            read_operation <= 1'b0;
            address        <= '0;
            write_data     <= '0;
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            rdata0         <= '0;
            rdata1         <= '0;
            hit0           <= 1'b0;
            hit1           <= 1'b0;
            err0           <= 1'b0;
            err1           <= 1'b0;
            busy           <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    // completion flags last exactly one cycle
                    ack0   <= 1'b0;
                    ack1   <= 1'b0;
                    rdata0 <= '0;
                    rdata1 <= '0;
                    hit0   <= 1'b0;
                    hit1   <= 1'b0;
                    err0   <= 1'b0;
                    err1   <= 1'b0;
                    if (|grant) begin
                        sel            <= grant[1];
                        read_operation <= grant[1] ? op1    : op0;
                        address        <= grant[1] ? addr1  : addr0;
                        write_data     <= grant[1] ? wdata1 : wdata0;
                        busy           <= 1'b1;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    start <= 1'b1;
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (hit || miss) begin
                        // hit wins when both flags arrive together
                        cap_data <= read_data;
                        cap_hit  <= hit;
                        cap_err  <= 1'b0;
                        start    <= 1'b0;
                        state    <= S_DONE;
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        cap_data <= '0;
                        cap_hit  <= 1'b0;
                        cap_err  <= 1'b1;
                        start    <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    ack0   <= ~sel;
                    ack1   <= sel;
                    rdata0 <= (!sel && read_operation) ? cap_data : '0;
                    rdata1 <= (sel && read_operation) ? cap_data : '0;
                    hit0   <= ~sel & cap_hit;
                    hit1   <= sel & cap_hit;
                    err0   <= ~sel & cap_err;
                    err1   <= sel & cap_err;
                    ptr    <= ~sel;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`else
    // A zero limit would be meaningless if the timeout were ever enabled
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    end

    assign err0 = 1'b0;
    assign err1 = 1'b0;

    always_ff @(posedge CC_clk) begin
        if (rst) begin
            state          <= S_IDLE;
            ptr            <= 1'b0;
            sel            <= 1'b0;
            cap_data       <= '0;
            cap_hit        <= 1'b0;
            start          <= 1'b0;
            read_operation <= 1'b0;
            address        <= '0;
            write_data     <= '0;
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            rdata0         <= '0;
            rdata1         <= '0;
            hit0           <= 1'b0;
            hit1           <= 1'b0;
            busy           <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    // completion flags last exactly one cycle
                    ack0   <= 1'b0;
                    ack1   <= 1'b0;
                    rdata0 <= '0;
                    rdata1 <= '0;
                    hit0   <= 1'b0;
                    hit1   <= 1'b0;
                    if (|grant) begin
                        sel            <= grant[1];
                        read_operation <= grant[1] ? op1    : op0;
                        address        <= grant[1] ? addr1  : addr0;
                        write_data     <= grant[1] ? wdata1 : wdata0;
                        busy           <= 1'b1;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    start <= 1'b1;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // unbounded wait for the cache to answer
                    if (hit || miss) begin
                        cap_data <= read_data;
                        cap_hit  <= hit;
                        start    <= 1'b0;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    ack0   <= ~sel;
                    ack1   <= sel;
                    rdata0 <= (!sel && read_operation) ? cap_data : '0;
                    rdata1 <= (sel && read_operation) ? cap_data : '0;
                    hit0   <= ~sel & cap_hit;
                    hit1   <= sel & cap_hit;
                    ptr    <= ~sel;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed self-checking bench for cache_port_arbiter.
// Covers reset, contention, write miss, single read, mid-WAIT reset, timeout.
module tb_cache_port_arbiter;

    logic       CC_clk = 1'b0;
    logic       rst;
    logic       req0, op0, req1, op1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1, hit0, hit1, err0, err1;
    logic [7:0] rdata0, rdata1;
    logic       start, read_operation, busy;
    logic [7:0] address, write_data, read_data;
    logic       hit, miss;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    always #5 CC_clk = ~CC_clk;

    cache_port_arbiter #(.TIMEOUT_CYCLES(16), .AW(8)) dut (
        .CC_clk         (CC_clk),
        .rst            (rst),
        .req0           (req0),
        .op0            (op0),
        .addr0          (addr0),
        .wdata0         (wdata0),
        .ack0           (ack0),
        .rdata0         (rdata0),
        .hit0           (hit0),
        .err0           (err0),
        .req1           (req1),
        .op1            (op1),
        .addr1          (addr1),
        .wdata1         (wdata1),
        .ack1           (ack1),
        .rdata1         (rdata1),
        .hit1           (hit1),
        .err1           (err1),
        .start          (start),
        .read_operation (read_operation),
        .address        (address),
        .write_data     (write_data),
        .read_data      (read_data),
        .hit            (hit),
        .miss           (miss),
        .busy           (busy)
    );

    task automatic step;
        @(posedge CC_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int seen;
        bit acked;
        rst = 1'b1;
        req0 = 0; op0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; op1 = 0; addr1 = 0; wdata1 = 0;
        read_data = 0; hit = 0; miss = 0;

        // reset state
        step; step;
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_addr", address, 0);
        chk("rst_rdop", read_operation, 0);
        chk("rst_wdata", write_data, 0);
        chk("rst_err0", err0, 0);
        rst = 1'b0;

        // contention: both rise together, req0 first
        req0 = 1; op0 = 1; addr0 = 8'h10;
        req1 = 1; op1 = 1; addr1 = 8'h20;
        step;
        chk("c0_addr", address, 8'h10);
        chk("c0_busy", busy, 1);
        chk("c0_issue_start", start, 0);
        step;
        chk("c0_wait_start", start, 1);
        hit = 1; read_data = 8'hA1;
        step;
        hit = 0; read_data = 0;
        chk("c_gap_done", start, 0);
        step;
        chk("c0_ack0", ack0, 1);
        chk("c0_rdata0", rdata0, 8'hA1);
        chk("c0_hit0", hit0, 1);
        chk("c0_ack1", ack1, 0);
        chk("c_gap_idle", start, 0);
        req0 = 0;
        step;
        chk("c1_addr", address, 8'h20);
        chk("c_gap_issue", start, 0);
        step;
        chk("c1_wait_start", start, 1);
        hit = 1; read_data = 8'hB2;
        step;
        hit = 0; read_data = 0;
        step;
        chk("c1_ack1", ack1, 1);
        chk("c1_rdata1", rdata1, 8'hB2);
        chk("c1_hit1", hit1, 1);
        chk("c1_ack0", ack0, 0);
        req1 = 0;
        step;
        chk("c1_ack_pulse", ack1, 0);
        chk("c1_busy", busy, 0);

        // write miss from requester 1; late input changes ignored
        req1 = 1; op1 = 0; addr1 = 8'h01; wdata1 = 8'h05;
        step; step;
        chk("w_start", start, 1);
        chk("w_wdata", write_data, 8'h05);
        chk("w_rdop", read_operation, 0);
        chk("w_addr", address, 8'h01);
        wdata1 = 8'hFF; addr1 = 8'hFE;
        step;
        chk("w_wdata_hold", write_data, 8'h05);
        chk("w_addr_hold", address, 8'h01);
        miss = 1; read_data = 8'h77;
        step;
        miss = 0; read_data = 0;
        step;
        chk("w_ack1", ack1, 1);
        chk("w_hit1", hit1, 0);
        chk("w_rdata1", rdata1, 0);
        chk("w_err1", err1, 0);
        req1 = 0; wdata1 = 0; addr1 = 0;
        step;

        // single read from requester 0, hit and miss together
        req0 = 1; op0 = 1; addr0 = 8'h00;
        step; step;
        hit = 1; miss = 1; read_data = 8'h0F;
        step;
        hit = 0; miss = 0; read_data = 0;
        step;
        chk("r_ack0", ack0, 1);
        chk("r_rdata0", rdata0, 8'h0F);
        chk("r_hit0", hit0, 1);
        chk("r_ack1", ack1, 0);
        req0 = 0;
        step;

        // round-robin: req0 served last, so req1 wins
        req0 = 1; op0 = 1; addr0 = 8'h40;
        req1 = 1; op1 = 1; addr1 = 8'h50;
        step;
        chk("rr_addr", address, 8'h50);
        step;
        chk("rr_start", start, 1);

        // reset during WAIT
        rst = 1;
        step;
        rst = 0;
        chk("mr_start", start, 0);
        chk("mr_busy", busy, 0);
        chk("mr_ack0", ack0, 0);
        chk("mr_ack1", ack1, 0);
        chk("mr_addr", address, 0);
        req0 = 0;
        step;
        chk("mr_reissue_addr", address, 8'h50);
        chk("mr_reissue_busy", busy, 1);
        step;
        chk("mr_reissue_start", start, 1);
        hit = 1; read_data = 8'hC3;
        step;
        hit = 0; read_data = 0;
        step;
        chk("mr_ack1", ack1, 1);
        chk("mr_rdata1", rdata1, 8'hC3);
        chk("mr_ack0", ack0, 0);
        req1 = 0;
        step;

        // cache never answers
        req0 = 1; op0 = 1; addr0 = 8'h33; read_data = 8'h5A;
`ifdef ARB_TIMEOUT_EN
        n = 0;
        acked = 0;
        for (int i = 0; i < 40 && !acked; i++) begin
            step;
            n++;
            if (ack0) acked = 1;
        end
        chk("to_latency", n, 19);
        chk("to_err0", err0, 1);
        chk("to_hit0", hit0, 0);
        chk("to_rdata0", rdata0, 0);
        chk("to_ack1", ack1, 0);
        req0 = 0;
        step;
        chk("to_busy", busy, 0);
`else
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step;
            if (ack0 || ack1) seen++;
        end
        chk("nt_no_ack", seen, 0);
        chk("nt_busy", busy, 1);
        chk("nt_start", start, 1);
        chk("nt_err0", err0, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cache_port_arbiter.md
CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: WAIT-state cycle limit, used only with ARB_TIMEOUT_EN.
REQ-002 SHALL have parameter AW, default 8: address width; data width is fixed at 8.
REQ-003 SHALL have port CC_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports reqN  input  1  requester N transaction request, N=0,1; level, held until ackN.
REQ-006 SHALL have ports opN  input  1  requester N read_operation: 1=read, 0=write.
REQ-007 SHALL have ports addrN  input  AW  requester N address.
REQ-008 SHALL have ports wdataN  input  8  requester N write data.
REQ-009 SHALL have ports ackN  output  1  one-cycle completion pulse to requester N.
REQ-010 SHALL have ports rdataN  output  8  read data to requester N, valid while ackN is high.
REQ-011 SHALL have ports hitN  output  1  cache hit flag to requester N, valid while ackN is high.
REQ-012 SHALL have ports errN  output  1  timeout flag to requester N, valid while ackN is high.
REQ-013 SHALL have port start  output  1  to cache_controller start.
REQ-014 SHALL have port read_operation  output  1  to cache_controller.
REQ-015 SHALL have port address  output  AW  to cache_controller.
REQ-016 SHALL have port write_data  output  8  to cache_controller.
REQ-017 SHALL have ports read_data  input  8, hit  input  1, miss  input  1, from cache_controller.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE, all outputs registered.
REQ-020 IDLE: if any reqN is sampled high, SHALL select a winner, latch its op/addr/wdata into cache-side outputs and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-021 Winner selection: a single request wins; if both are high, the winner SHALL be the requester not served last (round-robin pointer; reset value favours req0).
REQ-022 ISSUE: SHALL assert start=1 and go to WAIT; start SHALL stay high through WAIT.
REQ-023 WAIT: on the first cycle with hit|miss sampled high, SHALL capture read_data and hit and go to DONE.
REQ-024 If hit and miss are sampled high together, hit SHALL take priority (hitN=1).
REQ-025 DONE: start SHALL be 0, ack, rdata and hit SHALL be driven to the winner only, the pointer SHALL update to the other requester, and the FSM SHALL go to IDLE.
REQ-026 Latency: ackN SHALL rise 1 cycle after the cycle in which hit|miss is sampled; minimum req-to-ack is 4 cycles.
REQ-027 start SHALL fall for at least 2 cycles (DONE, IDLE) between transactions.
REQ-028 Cache-side outputs SHALL hold stable from ISSUE through WAIT; requester input changes after the latch SHALL be ignored.
REQ-029 For writes, rdataN SHALL be driven 0 on ackN.
REQ-030 The losing requester's reqN SHALL remain pending and be served in the next IDLE without starvation.

Reset
REQ-031 rst high at any edge, including mid-transaction, SHALL force IDLE and pointer=req0, and drive start, read_operation, address, write_data, ackN, rdataN, hitN, errN and busy to 0.
REQ-032 A transaction interrupted by reset SHALL produce no ack.

Configuration
REQ-033 With ARB_TIMEOUT_EN defined, a counter SHALL count WAIT cycles; at count TIMEOUT_CYCLES without hit|miss, the FSM SHALL go to DONE with errN=1, hitN=0 and rdataN=0.
REQ-034 Without ARB_TIMEOUT_EN, errN SHALL be tied 0, no counter SHALL exist, and WAIT SHALL be unbounded.

Structure
REQ-035 Package cc_arb_pkg SHALL hold the FSM state enum, NUM_REQ=2 and the default TIMEOUT_CYCLES.
REQ-036 Round-robin winner selection SHALL be the sub-module arb_rr_pick (inputs: req vector, pointer; output: one-hot grant).

Verification
REQ-037 Single read: req0, op0=1, addr0=0x00; cache returns hit with read_data=0x0F -> ack0 pulse, rdata0=0x0F, hit0=1, ack1 never asserted.
REQ-038 Contention: req0 and req1 rise in the same cycle after reset -> requester 0 served first, then requester 1; ack0 precedes ack1; start has a gap of at least 2 low cycles between them.
REQ-039 Write miss: req1, op1=0, addr1=0x01, wdata1=0x05; cache returns miss -> write_data=0x05 during WAIT, ack1 pulse with hit1=0 and rdata1=0.
REQ-040 Mid-operation reset: assert rst during WAIT -> next cycle start=0, busy=0, no ack; re-issuing the request completes normally.
REQ-041 Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): cache never responds -> ack0 with err0=1 after 16 WAIT cycles; without the macro, busy stays high indefinitely.
